clkdiv_ctrl: RTL and testbench

CLKDIV_CTRL -- requirements
Module: clkdiv_ctrl

---
 rtl/clkdiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clkdiv_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider with glitch-free ratio changes applied only at phase wrap.
// Optional stop/gate feature: define CLKDIV_CTRL_GATE_EN to add stop_req/stopped and the STOP state.
module clkdiv_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       div_req,
  input  logic [7:0] div_val,
`ifdef CLKDIV_CTRL_GATE_EN
  input  logic       stop_req,
  output logic       stopped,
`endif
  output logic       div_ack,
  output logic       div_err,
  output logic       busy,
  output logic [7:0] cur_div,
  output logic       div_clk,
  output logic       div_tick
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
`ifdef CLKDIV_CTRL_GATE_EN
    S_STOP = 2'd2,
`endif
    S_PEND = 2'd1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] pend_q, pend_d;
  logic       ack_d, err_d, busy_d, clk_d, tick_d;
  logic       div_clk_q, div_tick_q, div_ack_q, div_err_q, busy_q;
  logic       wrap_s, val_ok_s;
  logic [8:0] half_s;
`ifdef CLKDIV_CTRL_GATE_EN
  logic       stopped_q, stopped_d;
`endif

  // Next-state, phase counter and registered-output precomputation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    pend_d   = pend_q;
    ack_d    = 1'b0;
    val_ok_s = (div_val >= 8'd2);
    wrap_s   = (cnt_q == (cur_q - 8'd1));
    err_d    = div_req & ~val_ok_s;
    case (state_q)
      S_RUN: begin
        cnt_d = wrap_s ? 8'd0 : (cnt_q + 8'd1);
`ifdef CLKDIV_CTRL_GATE_EN
        // Stopping at this wrap: nothing is running, so a new ratio applies at once.
        if (wrap_s && stop_req) begin
          state_d = S_STOP;
          if (div_req && val_ok_s) begin
            cur_d = div_val;
            ack_d = 1'b1;
          end else begin
            cur_d = cur_q;
          end
        end else
`endif
        if (div_req && val_ok_s) begin
          pend_d  = div_val;
          state_d = S_PEND;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PEND: begin
        if (wrap_s) begin
          cur_d  = pend_q;
          pend_d = 8'd0;
          ack_d  = 1'b1;
          cnt_d  = 8'd0;
`ifdef CLKDIV_CTRL_GATE_EN
          state_d = stop_req ? S_STOP : S_RUN;
`else
          state_d = S_RUN;
`endif
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_PEND;
        end
      end
`ifdef CLKDIV_CTRL_GATE_EN
      S_STOP: begin
        if (div_req && val_ok_s) begin
          cur_d = div_val;
          ack_d = 1'b1;
        end else begin
          cur_d = cur_q;
        end
        if (!stop_req) begin
          state_d = S_RUN;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_STOP;
          cnt_d   = 8'd0;
        end
      end
`endif
      default: begin
        state_d = S_RUN;
        cnt_d   = 8'd0;
      end
    endcase
    half_s = ({1'b0, cur_d} + 9'd1) >> 1;
    clk_d  = ({1'b0, cnt_d} >= half_s);
    tick_d = clk_d & ~div_clk_q;
    busy_d = (state_d == S_PEND);
`ifdef CLKDIV_CTRL_GATE_EN
    stopped_d = (state_d == S_STOP);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      cnt_q      <= 8'd0;
      cur_q      <= 8'd2;
      pend_q     <= 8'd0;
      div_clk_q  <= 1'b0;
      div_tick_q <= 1'b0;
      div_ack_q  <= 1'b0;
      div_err_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CLKDIV_CTRL_GATE_EN
      stopped_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      div_clk_q  <= clk_d;
      div_tick_q <= tick_d;
      div_ack_q  <= ack_d;
      div_err_q  <= err_d;
      busy_q     <= busy_d;
`ifdef CLKDIV_CTRL_GATE_EN
      stopped_q  <= stopped_d;
`endif
    end
  end

  assign div_clk  = div_clk_q;
  assign div_tick = div_tick_q;
  assign div_ack  = div_ack_q;
  assign div_err  = div_err_q;
  assign busy     = busy_q;
  assign cur_div  = cur_q;
`ifdef CLKDIV_CTRL_GATE_EN
  assign stopped  = stopped_q;
`endif

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios plus randomized requests
// compared each cycle against a cycle-level behavioural model.
module tb_clkdiv_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack, div_err, busy, div_clk, div_tick;
  logic [7:0] cur_div;
`ifdef CLKDIV_CTRL_GATE_EN
  logic       stop_req;
  logic       stopped;
`endif

  clkdiv_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_req  (div_req),
    .div_val  (div_val),
`ifdef CLKDIV_CTRL_GATE_EN
    .stop_req (stop_req),
    .stopped  (stopped),
`endif
    .div_ack  (div_ack),
    .div_err  (div_err),
    .busy     (busy),
    .cur_div  (cur_div),
    .div_clk  (div_clk),
    .div_tick (div_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase position, ratio in effect, pending ratio (-1 = none).
  int m_cnt, m_cur, m_pend, m_clk, m_tick, m_ack, m_err, m_stop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cur = 2; m_pend = -1; m_clk = 0; m_tick = 0;
    m_ack = 0; m_err = 0; m_stop = 0;
  endtask

  task automatic model_step(input bit req, input int val, input bit stp);
    bit wrap;
    bit ok;
    int pend_old;
    int prev;
    wrap     = (m_cnt == m_cur - 1);
    ok       = req && (val >= 2);
    pend_old = m_pend;
    m_ack    = 0;
    m_err    = (req && val < 2) ? 1 : 0;
    if (m_stop != 0) begin
      if (ok) begin m_cur = val; m_ack = 1; end
      if (!stp) begin m_stop = 0; m_cnt = 1; end
    end else begin
      if (wrap) begin
        m_cnt = 0;
        if (pend_old >= 0) begin m_cur = pend_old; m_pend = -1; m_ack = 1; end
        if (stp) begin
          m_stop = 1;
          if (pend_old < 0 && ok) begin m_cur = val; m_ack = 1; ok = 0; end
        end
      end else begin
        m_cnt++;
      end
      if (pend_old < 0 && ok) m_pend = val;
    end
    prev   = m_clk;
    m_clk  = (m_cnt >= (m_cur + 1) / 2) ? 1 : 0;
    m_tick = (m_clk == 1 && prev == 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check_eq("div_clk",  div_clk,  m_clk);
    check_eq("div_tick", div_tick, m_tick);
    check_eq("div_ack",  div_ack,  m_ack);
    check_eq("div_err",  div_err,  m_err);
    check_eq("busy",     busy,     (m_pend >= 0) ? 1 : 0);
    check_eq("cur_div",  cur_div,  m_cur);
`ifdef CLKDIV_CTRL_GATE_EN
    check_eq("stopped",  stopped,  m_stop);
`endif
  endtask

  task automatic cycle(input bit req, input int val, input bit stp);
    div_req = req;
    div_val = val[7:0];
`ifdef CLKDIV_CTRL_GATE_EN
    stop_req = stp;
`endif
    @(posedge clk);
    model_step(req, val, stp);
    #1;
    compare_all();
  endtask

  int acks;
  bit stp_lvl;

  initial begin
    rst_n = 1'b0; div_req = 1'b0; div_val = 8'd0;
`ifdef CLKDIV_CTRL_GATE_EN
    stop_req = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Free run at the reset ratio.
    repeat (6) cycle(1'b0, 0, 1'b0);

    // Request ratio 5 when the phase is at 0.
    for (int i = 0; i < 300 && m_cnt != 0; i++) cycle(1'b0, 0, 1'b0);
    check_eq("wait_cnt0", m_cnt, 0);
    cycle(1'b1, 5, 1'b0);
    repeat (14) cycle(1'b0, 0, 1'b0);

    // Rejected ratios 1 and 0.
    cycle(1'b1, 1, 1'b0);
    cycle(1'b1, 0, 1'b0);
    repeat (3) cycle(1'b0, 0, 1'b0);

    // Second request while busy is ignored.
    acks = 0;
    cycle(1'b1, 7, 1'b0);
    cycle(1'b1, 9, 1'b0);
    acks += div_ack;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 0, 1'b0);
      acks += div_ack;
    end
    check_eq("ack_count_busy", acks, 1);
    check_eq("cur_after_busy", cur_div, 7);

    // Reset while a ratio is pending.
    cycle(1'b1, 4, 1'b0);
    cycle(1'b0, 0, 1'b0);
    check_eq("busy_before_rst", busy, 1);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 0, 1'b0);
      acks += div_ack;
    end
    check_eq("ack_after_rst", acks, 0);

    // Randomized traffic.
    stp_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      bit r;
      int v;
      int sel;
      r   = ($urandom % 6) == 0;
      sel = $urandom % 10;
      if (sel < 2)      v = $urandom % 2;
      else if (sel < 8) v = $urandom_range(12, 2);
      else              v = $urandom_range(255, 2);
`ifdef CLKDIV_CTRL_GATE_EN
      if (($urandom % 40) == 0) stp_lvl = ~stp_lvl;
`endif
      cycle(r, v, stp_lvl);
    end

`ifdef CLKDIV_CTRL_GATE_EN
    // Stop with N=6 requested at phase 2, then release.
    for (int i = 0; i < 600 && (m_stop != 0 || m_pend >= 0); i++) cycle(1'b0, 0, 1'b0);
    cycle(1'b1, 6, 1'b0);
    for (int i = 0; i < 600 && m_cur != 6; i++) cycle(1'b0, 0, 1'b0);
    check_eq("ratio6", cur_div, 6);
    for (int i = 0; i < 20 && m_cnt != 2; i++) cycle(1'b0, 0, 1'b0);
    check_eq("wait_cnt2", m_cnt, 2);
    repeat (3) cycle(1'b0, 0, 1'b1);
    check_eq("not_yet_stopped", stopped, 0);
    cycle(1'b0, 0, 1'b1);
    check_eq("stopped_at_wrap", stopped, 1);
    check_eq("stopped_clk_low", div_clk, 0);
    repeat (4) cycle(1'b0, 0, 1'b1);
    repeat (14) cycle(1'b0, 0, 1'b0);
    check_eq("resumed", stopped, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
